comb_y1: RTL and testbench
==========================

Name: comb_y1

Overview:
- Three-input boolean function evaluator.
- Combinational output Y is a fixed function of inputs A, B, C, selected by an 8-entry truth-table parameter.
- The default function is 3-input majority.
- Adds a registered copy of Y, the decoded minterm index, and a rising-edge event counter, so downstream clocked logic and the bench can observe the function without glitches.
- Sits as a leaf combinational/decoding cell in the lab datapath.

Parameters:
- TRUTH_TABLE, 8'b1110_1000: bit i is the value of Y when {A,B,C} == i (A is MSB). The default is majority: Y = AB + AC + BC.
- CNT_W, 8: width of the Y rising-edge counter.

Ports:
- clk  input  1  rising-edge clock for all registered outputs.
- rst  input  1  asynchronous, active-high reset.
- Y  output  1  combinational function output, TRUTH_TABLE[{A,B,C}].
- A  input  1  function input, MSB of the minterm index.
- B  input  1  function input, middle bit.
- C  input  1  function input, LSB.
- y_q  output  1  Y registered on clk.
- m_idx  output  3  combinational minterm index {A,B,C}.
- m_onehot  output  8  combinational one-hot minterm decode; bit {A,B,C} set.
- rise_cnt  output  CNT_W  count of 0->1 transitions of y_q.

Behaviour:
- Port declaration order is Y, A, B, C, clk, rst, y_q, m_idx, m_onehot, rise_cnt. Positional instantiation with (Y, A, B, C) must bind correctly; clk and rst may be left unconnected in purely combinational use.
- Y, m_idx and m_onehot are purely combinational:
  - no latency; Y changes in the same delta as A/B/C;
  - no dependence on clk or rst.
- With the default table: Y=1 for ABC in {011, 101, 110, 111}, and 0 otherwise.
- Any X/Z on A, B or C drives Y to X; no X-masking.
- Reset values, applied immediately on rst rising and held while rst=1: y_q=0, rise_cnt=0.
- y_q <= Y on each rising clk when rst=0. One-cycle latency.
- A private register y_prev holds the prior y_q; it resets to 0.
- rise_cnt increments by 1 on each clk when y_q=1 and y_prev=0.
- rise_cnt wraps modulo 2^CNT_W; no saturation.
- Reset asserted mid-operation clears y_q, y_prev and rise_cnt asynchronously. The first clock after rst deasserts samples Y normally.
- If Y is 1 at the first post-reset edge, y_q goes 1 and the following edge counts one rise.
- m_onehot always has exactly one bit set for known inputs.

Decomposition:
- Shared package comb_pkg holds:
  - MAJ3_TT = 8'b1110_1000;
  - XOR3_TT = 8'b1001_0110;
  - the minterm-index typedef (3-bit).
- One natural sub-module: minterm_dec3, a 3-to-8 one-hot decoder. It drives m_onehot; Y is the OR-reduction of (m_onehot & TRUTH_TABLE).

Test Plan:
- Exhaustive sweep: {A,B,C} counts 000..111, one step per 5 time units. Y must equal 0,0,0,1,0,1,1,1 (default table). m_idx must track the input, and m_onehot must be 1<<idx.
- Registered path: hold ABC=011 over a rising clk -> y_q=1 after exactly one edge. Set ABC=000 -> y_q=0 on the next edge.
- Edge counter: rst pulse, then toggle ABC between 000 and 111 every clock for 10 edges -> rise_cnt=5.
- Wrap: CNT_W=2, generate 5 rises -> rise_cnt reads 0,1,2,3,0,1 across the sequence.
- Async reset mid-run: rise_cnt=3, y_q=1; assert rst between edges -> y_q=0 and rise_cnt=0 immediately, with no clock needed.
- Alternate table: TRUTH_TABLE=XOR3_TT, sweep 000..111 -> Y = 0,1,1,0,1,0,0,1.

Source files
------------

// File: rtl/comb_pkg.sv
// Shared constants and types for the three-input function evaluator cells.
package comb_pkg;

    localparam logic [7:0] MAJ3_TT = 8'b1110_1000;
    localparam logic [7:0] XOR3_TT = 8'b1001_0110;

    typedef logic [2:0] minterm_t;

    function automatic logic [7:0] onehot3(input minterm_t idx);
        return 8'b0000_0001 << idx;
    endfunction

endpackage

// File: rtl/comb_y1_dec3.sv
// 3-to-8 one-hot minterm decoder; unknown index bits make the whole vector unknown.
module minterm_dec3
    import comb_pkg::*;
(
    input  minterm_t   idx,
    output logic [7:0] onehot
);

    assign onehot = onehot3(idx);

endmodule

// File: rtl/comb_y1.sv
// Table-driven three-input boolean cell with a registered copy of Y and a y_q rise counter.
module comb_y1
    import comb_pkg::*;
#(
    parameter logic [7:0]  TRUTH_TABLE = MAJ3_TT,
    parameter int unsigned CNT_W       = 8
) (
    output logic             Y,
    input  logic             A,
    input  logic             B,
    input  logic             C,
    input  logic             clk,
    input  logic             rst,
    output logic             y_q,
    output minterm_t         m_idx,
    output logic [7:0]       m_onehot,
    output logic [CNT_W-1:0] rise_cnt
);

    logic y_prev;

    assign m_idx = {A, B, C};

    minterm_dec3 u_dec (
        .idx    (m_idx),
        .onehot (m_onehot)
    );

    // Selecting through the one-hot keeps X on any input visible on Y.
    assign Y = |(m_onehot & TRUTH_TABLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q      <= 1'b0;
            y_prev   <= 1'b0;
            rise_cnt <= '0;
        end else begin
            y_q    <= Y;
            y_prev <= y_q;
            if (y_q && !y_prev)
                rise_cnt <= rise_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_comb_y1.sv
// Scoreboard bench for comb_y1: default, 2-bit counter, and XOR-table instances share stimulus.
module tb_comb_y1;
    import comb_pkg::*;

    localparam int SEL_Y      = 0;
    localparam int SEL_IDX    = 1;
    localparam int SEL_ONEHOT = 2;
    localparam int SEL_YQ     = 3;
    localparam int SEL_CNT    = 4;
    localparam int SEL_CNTW   = 5;
    localparam int SEL_YX     = 6;
    localparam int SEL_YQW    = 7;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    event sample_ev;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic A = 1'b0, B = 1'b0, C = 1'b0;

    logic       y, y_q;
    minterm_t   m_idx;
    logic [7:0] m_onehot;
    logic [7:0] rise_cnt;

    logic       y_w, y_q_w;
    minterm_t   m_idx_w;
    logic [7:0] m_onehot_w;
    logic [1:0] rise_cnt_w;

    logic       y_x, y_q_x;
    minterm_t   m_idx_x;
    logic [7:0] m_onehot_x;
    logic [7:0] rise_cnt_x;

    comb_y1 dut (
        .Y(y), .A(A), .B(B), .C(C), .clk(clk), .rst(rst),
        .y_q(y_q), .m_idx(m_idx), .m_onehot(m_onehot), .rise_cnt(rise_cnt)
    );

    comb_y1 #(.CNT_W(2)) dut_w (
        .Y(y_w), .A(A), .B(B), .C(C), .clk(clk), .rst(rst),
        .y_q(y_q_w), .m_idx(m_idx_w), .m_onehot(m_onehot_w), .rise_cnt(rise_cnt_w)
    );

    comb_y1 #(.TRUTH_TABLE(XOR3_TT)) dut_x (
        .Y(y_x), .A(A), .B(B), .C(C), .clk(clk), .rst(rst),
        .y_q(y_q_x), .m_idx(m_idx_x), .m_onehot(m_onehot_x), .rise_cnt(rise_cnt_x)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] actual(input int sel);
        case (sel)
            SEL_Y:      return {31'b0, y};
            SEL_IDX:    return {29'b0, m_idx};
            SEL_ONEHOT: return {24'b0, m_onehot};
            SEL_YQ:     return {31'b0, y_q};
            SEL_CNT:    return {24'b0, rise_cnt};
            SEL_CNTW:   return {30'b0, rise_cnt_w};
            SEL_YX:     return {31'b0, y_x};
            SEL_YQW:    return {31'b0, y_q_w};
            default:    return 'x;
        endcase
    endfunction

    // Monitor: drains every expectation queued before each sample strobe.
    initial begin
        forever begin
            @(sample_ev);
            while (sb.size() > 0) begin
                exp_t e;
                logic [31:0] act;
                e   = sb.pop_front();
                act = actual(e.sel);
                checks++;
                if (act !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got %0h expected %0h at t=%0t", e.name, act, e.exp, $time);
                end
            end
        end
    end

    task automatic expect_val(input string n, input int sel, input logic [31:0] e);
        exp_t item;
        item.name = n;
        item.sel  = sel;
        item.exp  = e;
        sb.push_back(item);
    endtask

    task automatic strobe();
        -> sample_ev;
        #0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic toggle_edges(input int n, input bit check_tbl);
        int cnt_tbl [10]  = '{0, 1, 1, 2, 2, 3, 3, 4, 4, 5};
        int cntw_tbl [10] = '{0, 1, 1, 2, 2, 3, 3, 0, 0, 1};
        for (int k = 0; k < n; k++) begin
            {A, B, C} = (k % 2 == 0) ? 3'b111 : 3'b000;
            step();
            if (check_tbl) begin
                expect_val($sformatf("tog_yq_%0d", k), SEL_YQ, (k % 2 == 0) ? 32'd1 : 32'd0);
                expect_val($sformatf("tog_cnt_%0d", k), SEL_CNT, 32'(cnt_tbl[k]));
                expect_val($sformatf("wrap_cnt_%0d", k), SEL_CNTW, 32'(cntw_tbl[k]));
                strobe();
            end
        end
    endtask

    initial begin
        int maj_tbl [8] = '{0, 0, 0, 1, 0, 1, 1, 1};
        int xor_tbl [8] = '{0, 1, 1, 0, 1, 0, 0, 1};

        #2;
        expect_val("rst_yq", SEL_YQ, 32'd0);
        expect_val("rst_cnt", SEL_CNT, 32'd0);
        expect_val("rst_cntw", SEL_CNTW, 32'd0);
        strobe();

        for (int i = 0; i < 8; i++) begin
            {A, B, C} = 3'(i);
            #1;
            expect_val($sformatf("maj_y_%0d", i), SEL_Y, 32'(maj_tbl[i]));
            expect_val($sformatf("idx_%0d", i), SEL_IDX, 32'(i));
            expect_val($sformatf("onehot_%0d", i), SEL_ONEHOT, 32'd1 << i);
            expect_val($sformatf("xor_y_%0d", i), SEL_YX, 32'(xor_tbl[i]));
            strobe();
            #4;
        end
        expect_val("rst_hold_yq", SEL_YQ, 32'd0);
        strobe();

        A = 1'bx; B = 1'b0; C = 1'b0;
        #1;
        expect_val("x_prop_y", SEL_Y, {31'b0, 1'bx});
        strobe();

        {A, B, C} = 3'b000;
        step();
        rst = 1'b0;
        {A, B, C} = 3'b011;
        #1;
        expect_val("reg_yq_before", SEL_YQ, 32'd0);
        strobe();
        step();
        expect_val("reg_yq_after", SEL_YQ, 32'd1);
        expect_val("reg_cnt_lag", SEL_CNT, 32'd0);
        strobe();
        {A, B, C} = 3'b000;
        step();
        expect_val("reg_yq_fall", SEL_YQ, 32'd0);
        expect_val("reg_cnt_rise", SEL_CNT, 32'd1);
        strobe();

        rst = 1'b1;
        #1;
        expect_val("pulse_yq", SEL_YQ, 32'd0);
        expect_val("pulse_cnt", SEL_CNT, 32'd0);
        strobe();
        #1;
        rst = 1'b0;
        toggle_edges(10, 1'b1);

        rst = 1'b1;
        #1;
        rst = 1'b0;
        toggle_edges(7, 1'b0);
        expect_val("mid_yq", SEL_YQ, 32'd1);
        expect_val("mid_cnt", SEL_CNT, 32'd3);
        strobe();
        #2;
        rst = 1'b1;
        #1;
        expect_val("async_yq", SEL_YQ, 32'd0);
        expect_val("async_cnt", SEL_CNT, 32'd0);
        expect_val("async_cntw", SEL_CNTW, 32'd0);
        strobe();

        {A, B, C} = 3'b111;
        step();
        expect_val("held_yq", SEL_YQ, 32'd0);
        strobe();
        rst = 1'b0;
        step();
        expect_val("post_rst_yq", SEL_YQ, 32'd1);
        expect_val("post_rst_yqw", SEL_YQW, 32'd1);
        expect_val("post_rst_cnt0", SEL_CNT, 32'd0);
        strobe();
        step();
        expect_val("post_rst_cnt1", SEL_CNT, 32'd1);
        strobe();

        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
